// File: rtl/card_dealer.sv
// Random non-repeating card source: LFSR-picked start index, linear probe over a 52-bit dealt mask.
// deal_req -> deal_valid in 2..53 cycles; requests while busy are ignored, shuffle aborts any search.
package poker_types;
    typedef enum logic [1:0] {CLUBS, DIAMONDS, HEARTS, SPADES} suit_t;
    typedef enum logic [3:0] {TWO, THREE, FOUR, FIVE, SIX, SEVEN, EIGHT, NINE, TEN,
                              JACK, QUEEN, KING, ACE} rank_t;
    typedef struct packed {
        rank_t rank;
        suit_t suit;
    } card_t;
endpackage

module card_dealer
    import poker_types::*;
#(
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       shuffle,
    input  logic       deal_req,
    output logic       deal_valid,
    output card_t      card,
    output logic [5:0] card_idx,
    output logic [5:0] cards_remaining,
    output logic       deck_empty,
    output logic       busy,
    output logic       deal_err
);
    typedef enum logic {IDLE, SEARCH} state_t;

    state_t      state_q, state_d;
    logic [51:0] dealt_q, dealt_d;
    logic [5:0]  rem_q, rem_d;
    logic [5:0]  cand_q, cand_d;
    logic [5:0]  idx_q, idx_d;
    card_t       card_q, card_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;
    logic        busy_q, busy_d;
    logic        empty_q, empty_d;
    logic [5:0]  lfsr_cand;

    // Suit-major ordering: idx = suit*13 + rank; comparisons avoid a divider.
    function automatic card_t idx_to_card(input logic [5:0] idx);
        card_t c;
        if (idx < 6'd13) begin
            c.suit = CLUBS;
            c.rank = rank_t'(idx[3:0]);
        end else if (idx < 6'd26) begin
            c.suit = DIAMONDS;
            c.rank = rank_t'(4'(idx - 6'd13));
        end else if (idx < 6'd39) begin
            c.suit = HEARTS;
            c.rank = rank_t'(4'(idx - 6'd26));
        end else begin
            c.suit = SPADES;
            c.rank = rank_t'(4'(idx - 6'd39));
        end
        return c;
    endfunction

    assign lfsr_d    = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    assign lfsr_cand = (lfsr_q[5:0] < 6'd52) ? lfsr_q[5:0] : lfsr_q[5:0] - 6'd52;

    always_comb begin
        state_d = state_q;
        dealt_d = dealt_q;
        rem_d   = rem_q;
        cand_d  = cand_q;
        idx_d   = idx_q;
        card_d  = card_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        if (shuffle) begin
            dealt_d = '0;
            rem_d   = 6'd52;
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (deal_req) begin
                        if (rem_q != 6'd0) begin
                            cand_d  = lfsr_cand;
                            state_d = SEARCH;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                SEARCH: begin
                    if (!dealt_q[cand_q]) begin
                        dealt_d[cand_q] = 1'b1;
                        idx_d   = cand_q;
                        card_d  = idx_to_card(cand_q);
                        rem_d   = rem_q - 6'd1;
                        valid_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        cand_d = (cand_q == 6'd51) ? 6'd0 : cand_q + 6'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        busy_d  = (state_d == SEARCH);
        empty_d = (rem_d == 6'd0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            dealt_q <= '0;
            rem_q   <= 6'd52;
            cand_q  <= '0;
            idx_q   <= '0;
            card_q  <= '0;
            lfsr_q  <= LFSR_SEED;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            empty_q <= 1'b0;
        end else begin
            state_q <= state_d;
            dealt_q <= dealt_d;
            rem_q   <= rem_d;
            cand_q  <= cand_d;
            idx_q   <= idx_d;
            card_q  <= card_d;
            lfsr_q  <= lfsr_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            empty_q <= empty_d;
        end
    end

    assign deal_valid      = valid_q;
    assign card            = card_q;
    assign card_idx        = idx_q;
    assign cards_remaining = rem_q;
    assign deck_empty      = empty_q;
    assign busy            = busy_q;
    assign deal_err        = err_q;
endmodule

// File: tb/tb_card_dealer.sv
// Directed bench for card_dealer with an independent LFSR/probe reference model.
module tb_card_dealer;
    import poker_types::*;

    localparam logic [15:0] SEED = 16'hACE1;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       shuffle = 1'b0;
    logic       deal_req = 1'b0;
    logic       deal_valid;
    card_t      card;
    logic [5:0] card_idx;
    logic [5:0] cards_remaining;
    logic       deck_empty;
    logic       busy;
    logic       deal_err;

    int n_cmp = 0;
    int n_fail = 0;

    logic [15:0] m_lfsr;
    bit   [51:0] m_dealt;
    int          m_rem;

    card_dealer #(.LFSR_SEED(SEED)) dut (
        .clk(clk), .reset(reset), .shuffle(shuffle), .deal_req(deal_req),
        .deal_valid(deal_valid), .card(card), .card_idx(card_idx),
        .cards_remaining(cards_remaining), .deck_empty(deck_empty),
        .busy(busy), .deal_err(deal_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset) m_lfsr <= SEED;
        else       m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        deal_req = 1'b0;
        shuffle = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        m_dealt = '0;
        m_rem = 52;
    endtask

    // Issue one request from IDLE; hold keeps deal_req high into the SEARCH cycle.
    task automatic do_deal(input bit hold, output int idx);
        int c, k, cnt, lo;
        lo = int'(m_lfsr[5:0]);
        c = (lo < 52) ? lo : lo - 52;
        k = 0;
        while (m_dealt[c]) begin
            c = (c == 51) ? 0 : c + 1;
            k++;
        end
        deal_req = 1'b1;
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
            if (cnt == 1) chk("busy_after_req", 64'(busy), 64'd1);
            if (cnt >= (hold ? 2 : 1)) deal_req = 1'b0;
        end while (!deal_valid && cnt < 60);
        chk("deal_latency", 64'(cnt), 64'(k + 2));
        chk("card_idx", 64'(card_idx), 64'(c));
        chk("card_rank", 64'(card.rank), 64'(c % 13));
        chk("card_suit", 64'(card.suit), 64'(c / 13));
        m_dealt[c] = 1'b1;
        m_rem--;
        chk("cards_remaining", 64'(cards_remaining), 64'(m_rem));
        chk("deck_empty", 64'(deck_empty), 64'(m_rem == 0));
        idx = c;
    endtask

    initial begin
        int idx, last_idx;
        logic [63:0] seen;
        int seq_a [3];
        int seq_b [3];

        do_reset();
        chk("rst_deal_valid", 64'(deal_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_deck_empty", 64'(deck_empty), 64'd0);
        chk("rst_deal_err", 64'(deal_err), 64'd0);
        chk("rst_card_idx", 64'(card_idx), 64'd0);
        chk("rst_card", 64'(card), 64'd0);
        chk("rst_remaining", 64'(cards_remaining), 64'd52);

        // First deal holds deal_req into SEARCH; the extra cycle must be ignored.
        seen = '0;
        do_deal(1'b1, idx);
        seen |= 64'd1 << idx;
        @(negedge clk);
        chk("single_pulse", 64'(deal_valid), 64'd0);
        @(negedge clk);
        chk("no_second_deal", 64'(deal_valid), 64'd0);
        chk("remaining_after_hold", 64'(cards_remaining), 64'd51);

        // Remaining 51 deals back-to-back, new request in the deal_valid cycle.
        for (int i = 0; i < 51; i++) begin
            do_deal(1'b0, idx);
            seen |= 64'd1 << idx;
        end
        last_idx = idx;
        chk("all_52_seen", seen, {12'd0, {52{1'b1}}});
        chk("empty_remaining", 64'(cards_remaining), 64'd0);
        chk("empty_flag", 64'(deck_empty), 64'd1);

        // Request on an empty deck.
        deal_req = 1'b1;
        @(negedge clk);
        deal_req = 1'b0;
        chk("err_pulse", 64'(deal_err), 64'd1);
        chk("err_no_valid", 64'(deal_valid), 64'd0);
        chk("err_no_busy", 64'(busy), 64'd0);
        @(negedge clk);
        chk("err_one_cycle", 64'(deal_err), 64'd0);
        chk("err_no_valid2", 64'(deal_valid), 64'd0);
        chk("err_idx_kept", 64'(card_idx), 64'(last_idx));

        // Shuffle refills the deck without touching the last card.
        shuffle = 1'b1;
        @(negedge clk);
        shuffle = 1'b0;
        m_dealt = '0;
        m_rem = 52;
        chk("shuf_remaining", 64'(cards_remaining), 64'd52);
        chk("shuf_empty", 64'(deck_empty), 64'd0);
        chk("shuf_idx_kept", 64'(card_idx), 64'(last_idx));

        // Shuffle during SEARCH aborts the deal.
        deal_req = 1'b1;
        @(negedge clk);
        deal_req = 1'b0;
        chk("abort_busy_before", 64'(busy), 64'd1);
        shuffle = 1'b1;
        @(negedge clk);
        shuffle = 1'b0;
        chk("abort_busy_after", 64'(busy), 64'd0);
        chk("abort_no_valid", 64'(deal_valid), 64'd0);
        chk("abort_remaining", 64'(cards_remaining), 64'd52);
        @(negedge clk);
        chk("abort_no_valid2", 64'(deal_valid), 64'd0);

        // Shuffle and deal_req together: request dropped.
        shuffle = 1'b1;
        deal_req = 1'b1;
        @(negedge clk);
        shuffle = 1'b0;
        deal_req = 1'b0;
        chk("drop_busy", 64'(busy), 64'd0);
        @(negedge clk);
        chk("drop_no_valid", 64'(deal_valid), 64'd0);
        chk("drop_remaining", 64'(cards_remaining), 64'd52);

        do_deal(1'b0, idx);

        // Reset in the probe cycle cancels the deal.
        @(negedge clk);
        deal_req = 1'b1;
        @(negedge clk);
        deal_req = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_dealt = '0;
        m_rem = 52;
        chk("rstmid_no_valid", 64'(deal_valid), 64'd0);
        chk("rstmid_busy", 64'(busy), 64'd0);
        @(negedge clk);
        chk("rstmid_no_valid2", 64'(deal_valid), 64'd0);
        chk("rstmid_remaining", 64'(cards_remaining), 64'd52);

        // Same stimulus timing after two resets yields the same sequence.
        do_reset();
        for (int i = 0; i < 3; i++) do_deal(1'b0, seq_a[i]);
        do_reset();
        for (int i = 0; i < 3; i++) do_deal(1'b0, seq_b[i]);
        for (int i = 0; i < 3; i++) chk("determinism", 64'(seq_b[i]), 64'(seq_a[i]));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/card_dealer.md
Name: card_dealer

Overview:
- Random, non-repeating card source for the hand FSM; sits directly upstream of the game logic that fills player_cards, flop_card, turn_card and river_card for top_screen.
- Keeps a 52-bit dealt mask and a free-running LFSR.
- On each deal request it returns one card not yet dealt since the last shuffle, using a valid pulse.
- One clock domain (clk, the 100 MHz system clock).

Parameters:
- LFSR_SEED, 16'hACE1, LFSR value loaded at reset; must be nonzero.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- shuffle  in  1  pulse; return all 52 cards to the deck
- deal_req  in  1  pulse; request one card
- deal_valid  out  1  one-cycle pulse; card/card_idx hold a newly dealt card
- card  out  card_t  dealt card (poker_types.svh packed struct)
- card_idx  out  6  dealt card index 0..51
- cards_remaining  out  6  undealt count 0..52
- deck_empty  out  1  high when cards_remaining == 0
- busy  out  1  high while a search is in progress (state SEARCH)
- deal_err  out  1  one-cycle pulse; deal_req arrived with the deck empty

Behaviour:
- Reset (synchronous, active-high):
  - dealt mask = 0, cards_remaining = 52, lfsr = LFSR_SEED, state IDLE.
  - deal_valid, deal_err, busy, deck_empty = 0; card_idx = 0; card = rank ordinal 0, suit ordinal 0.
  - Reset mid-search aborts the search; no deal_valid follows.
- LFSR:
  - 16-bit Fibonacci, advances every cycle it is not in reset, independent of state.
  - Update: fb = l[15]^l[13]^l[12]^l[10]; next value = {l[14:0], fb}.
- Index to card mapping:
  - suit ordinal = idx/13, rank ordinal = idx%13 (0 = Two .. 12 = Ace).
  - Both follow poker_types enum declaration order.
- States: IDLE, SEARCH.
- IDLE:
  - deal_req with cards_remaining > 0: cand <= (lfsr[5:0] < 52) ? lfsr[5:0] : lfsr[5:0] - 52. Go to SEARCH; busy = 1 from the next cycle.
  - deal_req with cards_remaining == 0: deal_err = 1 on the next cycle only. Stay in IDLE; nothing else changes.
- SEARCH, one probe per cycle:
  - dealt[cand] == 0: set dealt[cand]; card_idx and card <= cand (mapped); cards_remaining decrements. deal_valid = 1 on the next cycle; go to IDLE.
  - dealt[cand] == 1: cand <= (cand == 51) ? 0 : cand + 1 (linear probe with wrap).
  - The search always terminates because remaining > 0 is checked on entry.
- Latency:
  - deal_req sampled in cycle N gives deal_valid in cycle N+2 at best.
  - Worst case is N+53 (51 occupied probes).
- deal_req while busy, or in the cycle deal_valid is high with state already IDLE:
  - Ignored while busy.
  - Accepted in IDLE even when that is the same cycle deal_valid is high. Back-to-back deals are legal, one per ≥2 cycles.
- card and card_idx hold their last dealt value until the next deal_valid; they are not cleared by shuffle.
- shuffle has priority over everything except reset:
  - Clears the mask and sets cards_remaining = 52.
  - Aborts SEARCH to IDLE with no deal_valid.
  - deal_req in the same cycle is dropped.
  - The LFSR is not reseeded.
- deck_empty and busy are registered, consistent with cards_remaining and state in the same cycle.
- cards_remaining arithmetic is 6-bit. It never underflows, since decrement happens only on a successful probe.

Test Plan:
- Reset, then deal_req pulse: deal_valid high within 2–53 cycles; cards_remaining 52→51; card matches card_idx mapping (e.g. idx 51 → Ace, suit ordinal 3).
- 52 deal requests, each waiting for deal_valid: all 52 card_idx values distinct and together covering 0..51; deck_empty = 1 and cards_remaining = 0 after the last.
- 53rd deal_req on an empty deck: deal_err pulses for exactly one cycle; no deal_valid; card_idx unchanged.
- Deal 51 cards, then request the last: probe wraps past 51→0 if needed; the single remaining index is returned.
- shuffle asserted while busy = 1: busy drops next cycle, no deal_valid, cards_remaining = 52. shuffle + deal_req in the same cycle: request dropped.
- deal_req pulsed during SEARCH: ignored (exactly one deal_valid). Two resets with identical stimulus timing: identical card sequence (seed determinism against the reference model).
